// File: rtl/hex2binary_stream_pkg.sv
// Shared types and ASCII range constants for the hex-to-binary stream converter.
package hex2bin_pkg;

    typedef enum logic [0:0] {
        S_COLLECT = 1'b0,
        S_OUT     = 1'b1
    } state_t;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_9  = 8'h39;
    localparam logic [7:0] CH_UA = 8'h41;
    localparam logic [7:0] CH_UF = 8'h46;
    localparam logic [7:0] CH_LA = 8'h61;
    localparam logic [7:0] CH_LF = 8'h66;

endpackage

// File: rtl/hex2binary_stream_if.sv
// Character-in / word-out handshake bundle of hex2binary_stream.
interface hex2binary_stream_if #(parameter int N = 32);

    localparam int D  = N / 4;
    localparam int CW = $clog2(D + 1);

    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_char;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic [CW-1:0] out_digits;
    logic          err;

    modport master (
        output in_valid, in_char, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_digits, err
    );

    modport slave (
        input  in_valid, in_char, in_last, out_ready,
        output in_ready, out_valid, out_data, out_digits, err
    );

endinterface

// File: rtl/hex2binary_stream_hex_char_decode.sv
// ASCII character to hex nibble decoder.
// Lowercase 'a'-'f' are accepted only when HEX2BIN_LOWERCASE_EN is defined.
module hex_char_decode
    import hex2bin_pkg::*;
(
    input  logic [7:0] ch,
    output logic       is_hex,
    output logic [3:0] nibble
);

    // Letter codes have their value minus 9 in the low nibble.
    always_comb begin
        is_hex = 1'b0;
        nibble = 4'd0;
        if (ch >= CH_0 && ch <= CH_9) begin
            is_hex = 1'b1;
            nibble = ch[3:0];
        end else if (ch >= CH_UA && ch <= CH_UF) begin
            is_hex = 1'b1;
            nibble = ch[3:0] + 4'd9;
`ifdef HEX2BIN_LOWERCASE_EN
        end else if (ch >= CH_LA && ch <= CH_LF) begin
            is_hex = 1'b1;
            nibble = ch[3:0] + 4'd9;
`endif
        end else begin
            is_hex = 1'b0;
            nibble = 4'd0;
        end
    end

endmodule

// File: rtl/hex2binary_stream.sv
// Streaming ASCII-hex to N-bit binary converter (MSB-first digit accumulation).
// Optional lowercase support via HEX2BIN_LOWERCASE_EN (see hex_char_decode).
module hex2binary_stream
    import hex2bin_pkg::*;
#(
    parameter int N = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    hex2binary_stream_if.slave  bus
);

    localparam int D  = N / 4;
    localparam int CW = $clog2(D + 1);

    state_t        state_r, state_nx_s;
    logic [N-1:0]  acc_r, acc_nx_s;
    logic [N-1:0]  data_r, data_nx_s;
    logic [CW-1:0] cnt_r, cnt_nx_s;
    logic [CW-1:0] digits_r, digits_nx_s;
    logic          err_r, err_nx_s;
    logic          is_hex_s;
    logic [3:0]    nibble_s;

    hex_char_decode u_decode (
        .ch     (bus.in_char),
        .is_hex (is_hex_s),
        .nibble (nibble_s)
    );

    // Next-state, accumulator and output-register logic.
    always_comb begin
        state_nx_s  = state_r;
        acc_nx_s    = acc_r;
        cnt_nx_s    = cnt_r;
        data_nx_s   = data_r;
        digits_nx_s = digits_r;
        err_nx_s    = 1'b0;
        case (state_r)
            S_COLLECT: begin
                if (bus.in_valid) begin
                    if (is_hex_s) begin
                        acc_nx_s = (acc_r << 3'd4) | N'(nibble_s);
                        cnt_nx_s = cnt_r + CW'(1'b1);
                        if (cnt_nx_s == CW'(D) || bus.in_last) begin
                            data_nx_s   = acc_nx_s;
                            digits_nx_s = cnt_nx_s;
                            state_nx_s  = S_OUT;
                        end else begin
                            state_nx_s  = S_COLLECT;
                        end
                    end else begin
                        // A bad character throws away the whole partial word.
                        err_nx_s = 1'b1;
                        acc_nx_s = '0;
                        cnt_nx_s = '0;
                    end
                end else begin
                    state_nx_s = S_COLLECT;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    acc_nx_s   = '0;
                    cnt_nx_s   = '0;
                    state_nx_s = S_COLLECT;
                end else begin
                    state_nx_s = S_OUT;
                end
            end
            default: begin
                state_nx_s = S_COLLECT;
                acc_nx_s   = '0;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= S_COLLECT;
            acc_r    <= '0;
            cnt_r    <= '0;
            data_r   <= '0;
            digits_r <= '0;
            err_r    <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            acc_r    <= acc_nx_s;
            cnt_r    <= cnt_nx_s;
            data_r   <= data_nx_s;
            digits_r <= digits_nx_s;
            err_r    <= err_nx_s;
        end
    end

    assign bus.in_ready   = (state_r == S_COLLECT);
    assign bus.out_valid  = (state_r == S_OUT);
    assign bus.out_data   = data_r;
    assign bus.out_digits = digits_r;
    assign bus.err        = err_r;

endmodule

// File: tb/tb_hex2binary_stream.sv
// Directed self-checking bench for hex2binary_stream (N=32).
module tb_hex2binary_stream;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    hex2binary_stream_if #(.N(32)) bus ();

    hex2binary_stream #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one character for one clock edge, then sample point is 1ns after the edge.
    task automatic send(input logic [7:0] ch, input logic last);
        bus.in_valid = 1'b1;
        bus.in_char  = ch;
        bus.in_last  = last;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_str(input string s, input logic last);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i], (last && (i == s.len() - 1)));
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_char    = 8'h00;
        bus.in_last    = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (3) idle();

        chk("rst_out_valid", bus.out_valid, 64'd0);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_out_digits", bus.out_digits, 64'd0);
        chk("rst_err", bus.err, 64'd0);
        rst_n = 1'b1;
        idle();
        chk("rst_in_ready", bus.in_ready, 64'd1);

        // Full word, back to back
        send_str("DEADBEE", 1'b0);
        chk("full_no_early_valid", bus.out_valid, 64'd0);
        chk("full_in_ready_mid", bus.in_ready, 64'd1);
        send("F", 1'b0);
        chk("full_valid", bus.out_valid, 64'd1);
        chk("full_data", bus.out_data, 64'hDEADBEEF);
        chk("full_digits", bus.out_digits, 64'd8);
        chk("full_in_ready_low", bus.in_ready, 64'd0);
        chk("full_err", bus.err, 64'd0);
        idle();
        chk("full_valid_one_cycle", bus.out_valid, 64'd0);
        chk("full_in_ready_back", bus.in_ready, 64'd1);

        // Short word terminated by in_last
        send_str("1A", 1'b1);
        chk("short_valid", bus.out_valid, 64'd1);
        chk("short_data", bus.out_data, 64'h0000001A);
        chk("short_digits", bus.out_digits, 64'd2);
        chk("short_in_ready", bus.in_ready, 64'd0);
        idle();
        chk("short_valid_drop", bus.out_valid, 64'd0);

        // Single-digit word
        send("F", 1'b1);
        chk("one_digit_data", bus.out_data, 64'h0000000F);
        chk("one_digit_digits", bus.out_digits, 64'd1);
        idle();

        // Invalid character mid-word
        send_str("12", 1'b0);
        chk("inv_err_before", bus.err, 64'd0);
        send("G", 1'b0);
        chk("inv_err_pulse", bus.err, 64'd1);
        chk("inv_no_valid", bus.out_valid, 64'd0);
        send("4", 1'b1);
        chk("inv_err_one_cycle", bus.err, 64'd0);
        chk("inv_restart_valid", bus.out_valid, 64'd1);
        chk("inv_restart_data", bus.out_data, 64'h00000004);
        chk("inv_restart_digits", bus.out_digits, 64'd1);
        idle();
        send_str("00000001", 1'b0);
        chk("after_inv_valid", bus.out_valid, 64'd1);
        chk("after_inv_data", bus.out_data, 64'h00000001);
        chk("after_inv_digits", bus.out_digits, 64'd8);
        idle();

        // Invalid character carrying in_last: only err
        send_str("7", 1'b0);
        send("Z", 1'b1);
        chk("inv_last_err", bus.err, 64'd1);
        chk("inv_last_no_valid", bus.out_valid, 64'd0);
        idle();
        chk("inv_last_still_no_valid", bus.out_valid, 64'd0);

        // in_last without in_valid is ignored
        send_str("ABC", 1'b0);
        bus.in_last = 1'b1;
        idle();
        bus.in_last = 1'b0;
        chk("idle_last_no_valid", bus.out_valid, 64'd0);
        send_str("DEF01", 1'b0);
        chk("idle_last_data", bus.out_data, 64'hABCDEF01);
        chk("idle_last_digits", bus.out_digits, 64'd8);
        idle();

        // Backpressure: output held, input stalled
        bus.out_ready = 1'b0;
        send_str("CAFEF00D", 1'b0);
        bus.in_valid = 1'b1;
        bus.in_char  = "7";
        for (int k = 0; k < 5; k++) begin
            idle();
            chk("bp_valid", bus.out_valid, 64'd1);
            chk("bp_data", bus.out_data, 64'hCAFEF00D);
            chk("bp_in_ready", bus.in_ready, 64'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        chk("bp_release", bus.out_valid, 64'd0);
        send_str("1234567", 1'b1);
        chk("bp_next_data", bus.out_data, 64'h01234567);
        chk("bp_next_digits", bus.out_digits, 64'd7);
        idle();

        // Lowercase handling depends on configuration
`ifdef HEX2BIN_LOWERCASE_EN
        send_str("deadbeef", 1'b0);
        chk("lc_valid", bus.out_valid, 64'd1);
        chk("lc_data", bus.out_data, 64'hDEADBEEF);
        idle();
`else
        begin
            string lc;
            lc = "deadbeef";
            for (int i = 0; i < 8; i++) begin
                send(lc[i], 1'b0);
                chk("lc_err", bus.err, 64'd1);
                chk("lc_no_valid", bus.out_valid, 64'd0);
            end
            idle();
            chk("lc_err_clear", bus.err, 64'd0);
        end
`endif

        // Reset mid-word
        send_str("123", 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_data", bus.out_data, 64'd0);
        idle();
        chk("midrst_no_valid", bus.out_valid, 64'd0);
        chk("midrst_no_err", bus.err, 64'd0);
        rst_n = 1'b1;
        idle();
        send_str("89ABCDEF", 1'b0);
        chk("midrst_after_valid", bus.out_valid, 64'd1);
        chk("midrst_after_data", bus.out_data, 64'h89ABCDEF);
        chk("midrst_after_digits", bus.out_digits, 64'd8);

        // Reset while in S_OUT
        bus.out_ready = 1'b0;
        idle();
        rst_n = 1'b0;
        #1;
        chk("outrst_valid", bus.out_valid, 64'd0);
        chk("outrst_in_ready", bus.in_ready, 64'd1);
        idle();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
